// File: rtl/game_pkg.sv
// Shared game types and constants for the blackjack controller and its draw stages.
package game_pkg;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_PLAYER = 3'b001,
        ST_DEALER = 3'b010,
        ST_WIN    = 3'b011,
        ST_LOSE   = 3'b100,
        ST_DRAW   = 3'b101,
        ST_DEAL   = 3'b110
    } game_state_t;

    localparam int         DEALER_STAND_DEF = 17;
    localparam logic [5:0] BLACKJACK        = 6'd21;
    localparam logic [3:0] ACE_VALUE        = 4'd11;
endpackage

// File: rtl/hand_acc.sv
// One hand's running total; with SOFT_ACE_EN an ace may later drop from 11 to 1 on bust.
module hand_acc
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       add,
    input  logic [3:0] value,
    output logic [5:0] total
);
    logic [5:0] sum;

`ifdef SOFT_ACE_EN
    logic [1:0] ace_cnt;
    logic [1:0] ace_cnt_n;

    always_comb begin
        sum       = total + {2'b00, value};
        ace_cnt_n = ace_cnt + ((value == ACE_VALUE) ? 2'd1 : 2'd0);
        // Demote one soft ace from 11 to 1 when the hand would otherwise bust.
        if ((sum > BLACKJACK) && (ace_cnt_n != 2'd0)) begin
            sum       = sum - 6'd10;
            ace_cnt_n = ace_cnt_n - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total   <= '0;
            ace_cnt <= '0;
        end else if (clear) begin
            total   <= '0;
            ace_cnt <= '0;
        end else if (add) begin
            total   <= sum;
            ace_cnt <= ace_cnt_n;
        end
    end
`else
    always_comb begin
        sum = total + {2'b00, value};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total <= '0;
        end else if (clear) begin
            total <= '0;
        end else if (add) begin
            total <= sum;
        end
    end
`endif
endmodule

// File: rtl/game_fsm.sv
// Blackjack game sequencer: deal, player turn, dealer turn, result. Optional SOFT_ACE_EN
// enables soft-ace handling inside hand_acc.
module game_fsm
    import game_pkg::*;
#(
    parameter int DEALER_STAND = DEALER_STAND_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_hit,
    input  logic       btn_stand,
    output logic       card_req,
    input  logic       card_vld,
    input  logic [3:0] card_value,
    output logic [2:0] state,
    output logic [5:0] player_points,
    output logic [5:0] dealer_points
);
    game_state_t state_r, state_n;
    logic [1:0]  deal_cnt, deal_cnt_n;
    logic        req_dealer;
    logic        issue, issue_dealer, clear, accept;

    assign accept = card_req & card_vld;
    assign state  = state_r;

    always_comb begin
        state_n      = state_r;
        deal_cnt_n   = deal_cnt;
        issue        = 1'b0;
        issue_dealer = 1'b0;
        clear        = 1'b0;
        unique case (state_r)
            ST_IDLE, ST_WIN, ST_LOSE, ST_DRAW: begin
                if (btn_start) begin
                    state_n    = ST_DEAL;
                    deal_cnt_n = 2'd0;
                    clear      = 1'b1;
                end
            end
            ST_DEAL: begin
                if (accept) begin
                    deal_cnt_n = deal_cnt + 2'd1;
                    if (deal_cnt == 2'd3) state_n = ST_PLAYER;
                end else if (!card_req) begin
                    issue        = 1'b1;
                    issue_dealer = deal_cnt[0];
                end
            end
            // Decisions wait until no card is in flight so totals are always settled.
            ST_PLAYER: begin
                if (!card_req) begin
                    if (player_points > BLACKJACK) state_n = ST_LOSE;
                    else if (btn_stand)            state_n = ST_DEALER;
                    else if (btn_hit)              issue   = 1'b1;
                end
            end
            ST_DEALER: begin
                if (!card_req) begin
                    if (dealer_points > BLACKJACK) begin
                        state_n = ST_WIN;
                    end else if (dealer_points < 6'(DEALER_STAND)) begin
                        issue        = 1'b1;
                        issue_dealer = 1'b1;
                    end else if (player_points > dealer_points) begin
                        state_n = ST_WIN;
                    end else if (player_points < dealer_points) begin
                        state_n = ST_LOSE;
                    end else begin
                        state_n = ST_DRAW;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            deal_cnt   <= '0;
            card_req   <= 1'b0;
            req_dealer <= 1'b0;
        end else begin
            state_r  <= state_n;
            deal_cnt <= deal_cnt_n;
            if (issue) begin
                card_req   <= 1'b1;
                req_dealer <= issue_dealer;
            end else if (accept) begin
                card_req <= 1'b0;
            end
        end
    end

    hand_acc u_player (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .add   (accept & ~req_dealer),
        .value (card_value),
        .total (player_points)
    );

    hand_acc u_dealer (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .add   (accept & req_dealer),
        .value (card_value),
        .total (dealer_points)
    );
endmodule

// File: tb/tb_game_fsm.sv
// Directed bench for game_fsm; expectations go through a FIFO scoreboard.
module tb_game_fsm;
    logic       clk = 1'b0;
    logic       rst;
    logic       btn_start, btn_hit, btn_stand;
    logic       card_req, card_vld;
    logic [3:0] card_value;
    logic [2:0] state;
    logic [5:0] player_points, dealer_points;

    int n_cmp  = 0;
    int n_fail = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    game_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .btn_start     (btn_start),
        .btn_hit       (btn_hit),
        .btn_stand     (btn_stand),
        .card_req      (card_req),
        .card_vld      (card_vld),
        .card_value    (card_value),
        .state         (state),
        .player_points (player_points),
        .dealer_points (dealer_points)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        n_cmp++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", t, obs, e);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
        push_exp(tag, e);
        check(obs);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && card_req !== 1'b1; i++) @(negedge clk);
        chk("card_req_wait", {31'd0, card_req}, 32'd1);
    endtask

    task automatic give_card(input logic [3:0] v);
        wait_req();
        card_vld   = 1'b1;
        card_value = v;
        @(negedge clk);
        card_vld   = 1'b0;
        card_value = 4'd0;
    endtask

    task automatic pulse_start();
        btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
    endtask

    task automatic deal4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        pulse_start();
        give_card(a);
        give_card(b);
        give_card(c);
        give_card(d);
    endtask

    task automatic no_req_for(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (card_req !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        chk(tag, {31'd0, seen}, 32'd0);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s);
        for (int i = 0; i < 40 && state !== s; i++) @(negedge clk);
        chk(tag, {29'd0, state}, {29'd0, s});
    endtask

    initial begin
        rst = 1'b1; btn_start = 1'b0; btn_hit = 1'b0; btn_stand = 1'b0;
        card_vld = 1'b0; card_value = 4'd0;
        @(negedge clk);
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_req", {31'd0, card_req}, 32'd0);
        chk("rst_player", {26'd0, player_points}, 32'd0);
        chk("rst_dealer", {26'd0, dealer_points}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Equal 17s: stand gives DRAW two cycles later, dealer stands on 17.
        deal4(4'd10, 4'd9, 4'd7, 4'd8);
        chk("t1_state_player", {29'd0, state}, 32'd1);
        chk("t1_player", {26'd0, player_points}, 32'd17);
        chk("t1_dealer", {26'd0, dealer_points}, 32'd17);
        push_exp("t1_dealer_after_stand", 32'd2);
        push_exp("t1_draw", 32'd5);
        btn_stand = 1'b1;
        @(negedge clk);
        btn_stand = 1'b0;
        check({29'd0, state});
        @(negedge clk);
        check({29'd0, state});
        no_req_for("t1_no_dealer_card", 4);
        chk("t1_hold_state", {29'd0, state}, 32'd5);

        // Player 19 vs dealer 17 wins.
        deal4(4'd10, 4'd10, 4'd9, 4'd7);
        chk("t2_player", {26'd0, player_points}, 32'd19);
        btn_stand = 1'b1;
        @(negedge clk);
        btn_stand = 1'b0;
        @(negedge clk);
        chk("t2_win", {29'd0, state}, 32'd3);
        chk("t2_dealer", {26'd0, dealer_points}, 32'd17);

        // Player busts on a hit; LOSE two cycles after card_vld, dealer never draws.
        deal4(4'd10, 4'd6, 4'd5, 4'd10);
        chk("t3_player15", {26'd0, player_points}, 32'd15);
        chk("t3_dealer16", {26'd0, dealer_points}, 32'd16);
        btn_hit = 1'b1;
        @(negedge clk);
        btn_hit = 1'b0;
        give_card(4'd9);
        chk("t3_player24", {26'd0, player_points}, 32'd24);
        chk("t3_not_yet_lose", {29'd0, state}, 32'd1);
        @(negedge clk);
        chk("t3_lose", {29'd0, state}, 32'd4);
        no_req_for("t3_no_dealer_card", 4);
        chk("t3_dealer_held", {26'd0, dealer_points}, 32'd16);

        // Two aces to the player.
        deal4(4'd11, 4'd10, 4'd11, 4'd7);
`ifdef SOFT_ACE_EN
        chk("t4_player_soft", {26'd0, player_points}, 32'd12);
        @(negedge clk);
        chk("t4_still_player", {29'd0, state}, 32'd1);
        btn_stand = 1'b1;
        @(negedge clk);
        btn_stand = 1'b0;
        @(negedge clk);
        chk("t4_lose", {29'd0, state}, 32'd4);
`else
        chk("t4_player_hard", {26'd0, player_points}, 32'd22);
        @(negedge clk);
        chk("t4_lose", {29'd0, state}, 32'd4);
`endif

        // start ignored in PLAYER; hit+stand together goes to DEALER with no player card.
        deal4(4'd10, 4'd9, 4'd7, 4'd8);
        pulse_start();
        chk("t5_start_ignored", {29'd0, state}, 32'd1);
        btn_hit = 1'b1;
        btn_stand = 1'b1;
        @(negedge clk);
        btn_hit = 1'b0;
        btn_stand = 1'b0;
        chk("t5_dealer", {29'd0, state}, 32'd2);
        chk("t5_no_req", {31'd0, card_req}, 32'd0);
        @(negedge clk);
        chk("t5_draw", {29'd0, state}, 32'd5);
        chk("t5_player", {26'd0, player_points}, 32'd17);

        // Dealer on 16 must draw; 16+10 busts -> WIN.
        deal4(4'd10, 4'd10, 4'd9, 4'd6);
        btn_stand = 1'b1;
        @(negedge clk);
        btn_stand = 1'b0;
        give_card(4'd10);
        chk("t6_dealer26", {26'd0, dealer_points}, 32'd26);
        wait_state("t6_win", 3'd3);

        // Dealer draws to 21 against player 19 -> LOSE.
        deal4(4'd10, 4'd5, 4'd9, 4'd6);
        btn_stand = 1'b1;
        @(negedge clk);
        btn_stand = 1'b0;
        give_card(4'd10);
        wait_state("t7_lose", 3'd4);
        chk("t7_dealer21", {26'd0, dealer_points}, 32'd21);

        // Async reset mid-deal with a request outstanding.
        pulse_start();
        give_card(4'd10);
        wait_req();
        #2 rst = 1'b1;
        #1;
        chk("t8_rst_state", {29'd0, state}, 32'd0);
        chk("t8_rst_req", {31'd0, card_req}, 32'd0);
        chk("t8_rst_player", {26'd0, player_points}, 32'd0);
        chk("t8_rst_dealer", {26'd0, dealer_points}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        card_vld = 1'b1;
        card_value = 4'd5;
        @(negedge clk);
        card_vld = 1'b0;
        card_value = 4'd0;
        @(negedge clk);
        chk("t8_vld_ignored_p", {26'd0, player_points}, 32'd0);
        chk("t8_vld_ignored_d", {26'd0, dealer_points}, 32'd0);
        chk("t8_idle", {29'd0, state}, 32'd0);
        chk("t8_req_low", {31'd0, card_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
